ascon_absorb: RTL and testbench

- Rate-absorption stage sitting directly upstream of the ASCON permutation core in the AEAD128a datapath.
- Accepts a byte stream as 32-bit words over a valid/ready handshake and assembles 128-bit rate blocks.
- Applies 10* padding, XORs each block into the rate lanes of the 320-bit state, and launches the permutation per block, latching its result.
- Signals completion when the final padded block has been permuted.

---
 rtl/ascon_absorb.sv | 147 ++++++++++++++
 tb/tb_ascon_absorb.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_absorb.sv
// ASCON rate absorption: packs 32-bit words into 128-bit rate blocks, applies 10* padding, drives the permutation.
// Optional ASCON_ABSORB_DOMSEP_EN flips state[0] on entry to DONE (AD/payload domain separation).
module ascon_absorb #(
  parameter int PERM_ROUNDS = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         state_load_i,
  input  logic [319:0] state_i,
  input  logic [31:0]  data_i,
  input  logic         data_valid_i,
  input  logic         data_last_i,
  input  logic [2:0]   data_bytes_i,
  output logic         data_ready_o,
  output logic         perm_start_o,
  output logic [319:0] perm_state_o,
  output logic [3:0]   perm_rounds_o,
  input  logic         perm_done_i,
  input  logic [319:0] perm_state_i,
  output logic [319:0] state_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_PERM = 3'd2;
  localparam logic [2:0] S_PAD  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]   fsm_q;
  logic [319:0] state_q;
  logic [127:0] blk_q;
  logic [1:0]   cnt_q;
  logic         final_q;
  logic         pad_pending_q;
  logic         start_q;

  logic [2:0]   n_eff;
  logic [31:0]  blk_word;
  logic [127:0] new_blk;
  logic         accept;
  logic         absorb;
  logic         to_done;
  logic [319:0] perm_res;

  // Keep bytes 0..n-1 (byte 0 is the MSB), put the 0x80 pad marker at byte n, zero the rest.
  function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [2:0] n);
    logic [31:0] r;
    int          ni;
    r  = '0;
    ni = int'(n);
    for (int b = 0; b < 4; b++) begin
      if (b < ni) r[31-8*b -: 8] = w[31-8*b -: 8];
      else if (b == ni) r[31-8*b -: 8] = 8'h80;
    end
    return r;
  endfunction

  always_comb begin
    n_eff    = (data_bytes_i > 3'd4) ? 3'd4 : data_bytes_i;
    blk_word = data_last_i ? pad_word(data_i, n_eff) : data_i;
    new_blk  = blk_q;
    for (int k = 0; k < 4; k++) begin
      if (k == int'(cnt_q)) new_blk[127-32*k -: 32] = blk_word;
      else if (data_last_i && n_eff == 3'd4 && k == int'(cnt_q) + 1)
        new_blk[127-32*k -: 32] = 32'h8000_0000;
    end
    accept  = (fsm_q == S_FILL) && data_valid_i;
    absorb  = accept && (data_last_i || cnt_q == 2'd3);
    to_done = final_q && !pad_pending_q;
`ifdef ASCON_ABSORB_DOMSEP_EN
    perm_res = perm_state_i ^ {319'b0, to_done};
`else
    perm_res = perm_state_i;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q         <= S_IDLE;
      state_q       <= '0;
      blk_q         <= '0;
      cnt_q         <= '0;
      final_q       <= 1'b0;
      pad_pending_q <= 1'b0;
      start_q       <= 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (state_load_i) begin
            state_q       <= state_i;
            blk_q         <= '0;
            cnt_q         <= '0;
            final_q       <= 1'b0;
            pad_pending_q <= 1'b0;
            fsm_q         <= S_FILL;
          end
        end
        S_FILL: begin
          if (accept) begin
            blk_q <= new_blk;
            if (absorb) begin
              state_q[319:192] <= state_q[319:192] ^ new_blk;
              final_q          <= data_last_i;
              pad_pending_q    <= data_last_i && n_eff == 3'd4 && cnt_q == 2'd3;
              start_q          <= 1'b1;
              fsm_q            <= S_PERM;
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end
        end
        S_PERM: begin
          start_q <= 1'b0;
          // The start cycle never consumes a result, so a stale done cannot alias the new launch.
          if (!start_q && perm_done_i) begin
            state_q <= perm_res;
            blk_q   <= '0;
            cnt_q   <= '0;
            if (pad_pending_q) fsm_q <= S_PAD;
            else if (final_q)  fsm_q <= S_DONE;
            else               fsm_q <= S_FILL;
          end
        end
        S_PAD: begin
          state_q[319:312] <= state_q[319:312] ^ 8'h80;
          pad_pending_q    <= 1'b0;
          final_q          <= 1'b1;
          start_q          <= 1'b1;
          fsm_q            <= S_PERM;
        end
        S_DONE:  fsm_q <= S_IDLE;
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  assign data_ready_o  = (fsm_q == S_FILL);
  assign perm_start_o  = (fsm_q == S_PERM) && start_q;
  assign perm_state_o  = state_q;
  assign perm_rounds_o = 4'(PERM_ROUNDS);
  assign state_o       = state_q;
  assign busy_o        = (fsm_q != S_IDLE);
  assign done_o        = (fsm_q == S_DONE);

endmodule

// File: tb/tb_ascon_absorb.sv
// Bench for ascon_absorb: scoreboard of expected permutation inputs plus a behavioural permutation responder.
module tb_ascon_absorb;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         state_load_i = 1'b0;
  logic [319:0] state_i = '0;
  logic [31:0]  data_i = '0;
  logic         data_valid_i = 1'b0;
  logic         data_last_i = 1'b0;
  logic [2:0]   data_bytes_i = '0;
  logic         data_ready_o;
  logic         perm_start_o;
  logic [319:0] perm_state_o;
  logic [3:0]   perm_rounds_o;
  logic         perm_done_i = 1'b0;
  logic [319:0] perm_state_i = '0;
  logic [319:0] state_o;
  logic         busy_o;
  logic         done_o;

  always #5 clk = ~clk;

  ascon_absorb #(.PERM_ROUNDS(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .state_load_i(state_load_i), .state_i(state_i),
    .data_i(data_i), .data_valid_i(data_valid_i), .data_last_i(data_last_i),
    .data_bytes_i(data_bytes_i), .data_ready_o(data_ready_o), .perm_start_o(perm_start_o),
    .perm_state_o(perm_state_o), .perm_rounds_o(perm_rounds_o), .perm_done_i(perm_done_i),
    .perm_state_i(perm_state_i), .state_o(state_o), .busy_o(busy_o), .done_o(done_o)
  );

  localparam logic [319:0] MIX = {5{64'h0123_4567_89AB_CDEF}};
  localparam logic [319:0] PAD80 = {8'h80, 312'b0};

  int n_checks = 0;
  int n_pass = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int perm_lat = 3;
  logic [319:0] exp_q[$];
  logic [319:0] mon_e;
  logic [319:0] cap = '0;
  logic         pend = 1'b0;
  int           cd = 0;

  function automatic logic [319:0] perm_f(input logic [319:0] x);
    return {x[318:0], x[319]} ^ MIX;
  endfunction

  function automatic logic [319:0] fin(input logic [319:0] r);
`ifdef ASCON_ABSORB_DOMSEP_EN
    return r ^ 320'd1;
`else
    return r;
`endif
  endfunction

  function automatic logic [319:0] rate(input logic [127:0] b);
    return {b, 192'b0};
  endfunction

  // Permutation responder and scoreboard pop on each launch
  always @(negedge clk) begin
    perm_done_i = 1'b0;
    if (pend) begin
      if (cd == 0) begin
        perm_done_i  = 1'b1;
        perm_state_i = perm_f(cap);
        pend         = 1'b0;
      end else cd--;
    end
    if (rst_n && perm_start_o) begin
      start_cnt++;
      n_checks++;
      if (exp_q.size() == 0)
        $display("FAIL perm_start_unexpected got=%h", perm_state_o);
      else begin
        mon_e = exp_q.pop_front();
        if (perm_state_o !== mon_e)
          $display("FAIL perm_state_at_start got=%h exp=%h", perm_state_o, mon_e);
        else n_pass++;
      end
      cap  = perm_state_o;
      pend = 1'b1;
      cd   = perm_lat - 1;
    end
    if (rst_n && done_o) done_cnt++;
  end

  task automatic load_state(input logic [319:0] s);
    state_i = s; state_load_i = 1'b1;
    @(posedge clk); #1;
    state_load_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb, input int gap);
    logic ok;
    ok = 1'b0;
    data_valid_i = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    data_i = d; data_last_i = last; data_bytes_i = nb; data_valid_i = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (data_ready_o) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    data_valid_i = 1'b0; data_last_i = 1'b0;
    if (!ok) begin n_checks++; $display("FAIL send_timeout ready=%b exp=1", data_ready_o); end
  endtask

  task automatic wait_done(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done_o) begin seen = 1'b1; break; end
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({data_ready_o, perm_start_o, busy_o, done_o, perm_rounds_o} !== {4'b0, 4'd8})
      $display("FAIL reset_ctrl got=%b exp=%b", {data_ready_o, perm_start_o, busy_o, done_o, perm_rounds_o}, {4'b0, 4'd8});
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (state_o !== '0 || perm_state_o !== '0)
      $display("FAIL reset_state got=%h exp=0", state_o);
    else n_pass++;
    n_checks++;
    if ({data_ready_o, busy_o, done_o} !== 3'b000)
      $display("FAIL reset_idle got=%b exp=000", {data_ready_o, busy_o, done_o});
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_empty();
    int s0, d0;
    logic seen;
    s0 = start_cnt; d0 = done_cnt;
    load_state('0);
    exp_q.push_back(PAD80);
    send_word(32'h1234_5678, 1'b1, 3'd0, 0);
    wait_done(seen);
    n_checks++;
    if (!seen || state_o !== fin(perm_f(PAD80)))
      $display("FAIL empty_final seen=%b got=%h exp=%h", seen, state_o, fin(perm_f(PAD80)));
    else n_pass++;
    n_checks++;
    if (start_cnt - s0 != 1 || done_cnt - d0 != 1)
      $display("FAIL empty_counts starts=%0d dones=%0d exp=1/1", start_cnt - s0, done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_full_partial();
    int s0;
    logic seen;
    logic [319:0] e1, e2;
    s0 = start_cnt;
    e1 = rate(128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F);
    e2 = perm_f(e1) ^ rate({32'hAABB_8000, 96'b0});
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    load_state('0);
    send_word(32'h0001_0203, 1'b0, 3'd0, 0);
    send_word(32'h0405_0607, 1'b0, 3'd0, 0);
    send_word(32'h0809_0A0B, 1'b0, 3'd0, 0);
    send_word(32'h0C0D_0E0F, 1'b0, 3'd0, 0);
    send_word(32'hAABB_CCDD, 1'b1, 3'd2, 0);
    wait_done(seen);
    n_checks++;
    if (!seen || state_o !== fin(perm_f(e2)))
      $display("FAIL full_partial_final seen=%b got=%h exp=%h", seen, state_o, fin(perm_f(e2)));
    else n_pass++;
    n_checks++;
    if (start_cnt - s0 != 2) $display("FAIL full_partial_starts got=%0d exp=2", start_cnt - s0);
    else n_pass++;
  endtask

  task automatic test_exact16();
    int s0;
    logic seen;
    logic [319:0] st, e1, e2;
    s0 = start_cnt;
    st = {5{64'hDEAD_BEEF_0123_4567}};
    e1 = st ^ rate(128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF00);
    e2 = perm_f(e1) ^ PAD80;
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    load_state(st);
    send_word(32'h1122_3344, 1'b0, 3'd0, 0);
    send_word(32'h5566_7788, 1'b0, 3'd0, 0);
    send_word(32'h99AA_BBCC, 1'b0, 3'd0, 0);
    send_word(32'hDDEE_FF00, 1'b1, 3'd4, 0);
    wait_done(seen);
    n_checks++;
    if (!seen || state_o !== fin(perm_f(e2)))
      $display("FAIL exact16_final seen=%b got=%h exp=%h", seen, state_o, fin(perm_f(e2)));
    else n_pass++;
    n_checks++;
    if (start_cnt - s0 != 2) $display("FAIL exact16_starts got=%0d exp=2", start_cnt - s0);
    else n_pass++;
  endtask

  task automatic test_last_at_cnt1();
    int s0;
    logic seen;
    logic [319:0] st, e1;
    s0 = start_cnt;
    st = {5{64'h0F1E_2D3C_4B5A_6978}};
    e1 = st ^ rate({32'hCAFE_BABE, 32'h1357_9BDF, 32'h8000_0000, 32'h0});
    exp_q.push_back(e1);
    load_state(st);
    send_word(32'hCAFE_BABE, 1'b0, 3'd0, 0);
    send_word(32'h1357_9BDF, 1'b1, 3'd4, 0);
    wait_done(seen);
    n_checks++;
    if (!seen || state_o !== fin(perm_f(e1)))
      $display("FAIL cnt1_final seen=%b got=%h exp=%h", seen, state_o, fin(perm_f(e1)));
    else n_pass++;
    n_checks++;
    if (start_cnt - s0 != 1) $display("FAIL cnt1_starts got=%0d exp=1", start_cnt - s0);
    else n_pass++;
  endtask

  task automatic test_partial_bytes();
    logic seen;
    logic [319:0] e1, e2;
    // One kept byte at word 0, then an oversize byte count at word 2 behaving as 4.
    e1 = rate({32'hAA80_0000, 96'b0});
    exp_q.push_back(e1);
    load_state('0);
    send_word(32'hAABB_CCDD, 1'b1, 3'd1, 0);
    wait_done(seen);
    n_checks++;
    if (!seen || state_o !== fin(perm_f(e1)))
      $display("FAIL bytes1_final seen=%b got=%h exp=%h", seen, state_o, fin(perm_f(e1)));
    else n_pass++;
    e2 = rate({32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h8000_0000});
    exp_q.push_back(e2);
    load_state('0);
    send_word(32'h0102_0304, 1'b0, 3'd0, 0);
    send_word(32'h0506_0708, 1'b0, 3'd0, 0);
    send_word(32'h090A_0B0C, 1'b1, 3'd6, 0);
    wait_done(seen);
    n_checks++;
    if (!seen || state_o !== fin(perm_f(e2)))
      $display("FAIL bytes_clamp_final seen=%b got=%h exp=%h", seen, state_o, fin(perm_f(e2)));
    else n_pass++;
  endtask

  task automatic test_handshake();
    int s0;
    logic seen, ready_bad, hold_bad, busy_bad;
    logic [319:0] st, e1, e2;
    s0 = start_cnt;
    perm_lat = 20;
    st = {5{64'h5A5A_A5A5_3C3C_C3C3}};
    e1 = st ^ rate(128'h1111_2222_3333_4444_5555_6666_7777_8888);
    e2 = perm_f(e1) ^ PAD80;
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    load_state(st);
    send_word(32'h1111_2222, 1'b0, 3'd0, $urandom_range(0, 3));
    send_word(32'h3333_4444, 1'b0, 3'd0, $urandom_range(0, 3));
    send_word(32'h5555_6666, 1'b0, 3'd0, $urandom_range(0, 3));
    send_word(32'h7777_8888, 1'b0, 3'd0, $urandom_range(0, 3));
    ready_bad = 1'b0; hold_bad = 1'b0; busy_bad = 1'b0;
    data_i = 32'hFFFF_FFFF; data_valid_i = 1'b1;
    state_i = '1; state_load_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (data_ready_o !== 1'b0) ready_bad = 1'b1;
      if (perm_state_o !== e1) hold_bad = 1'b1;
      if (busy_o !== 1'b1) busy_bad = 1'b1;
    end
    state_load_i = 1'b0; data_valid_i = 1'b0;
    n_checks++;
    if (ready_bad) $display("FAIL hs_ready_in_perm got=1 exp=0");
    else n_pass++;
    n_checks++;
    if (hold_bad || busy_bad) $display("FAIL hs_perm_hold stable_bad=%b busy_bad=%b exp=0/0", hold_bad, busy_bad);
    else n_pass++;
    send_word(32'h0, 1'b1, 3'd0, 0);
    wait_done(seen);
    n_checks++;
    if (!seen || state_o !== fin(perm_f(e2)))
      $display("FAIL hs_final seen=%b got=%h exp=%h", seen, state_o, fin(perm_f(e2)));
    else n_pass++;
    n_checks++;
    if (start_cnt - s0 != 2) $display("FAIL hs_starts got=%0d exp=2", start_cnt - s0);
    else n_pass++;
    perm_lat = 3;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset_in_perm();
    int d0;
    logic [319:0] st;
    perm_lat = 10;
    st = {5{64'h7654_3210_FEDC_BA98}};
    exp_q.push_back(st ^ PAD80);
    load_state(st);
    send_word(32'h0, 1'b1, 3'd0, 0);
    d0 = done_cnt;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (state_o !== '0 || busy_o !== 1'b0)
      $display("FAIL rst_perm_abort busy=%b state=%h exp=0", busy_o, state_o);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    n_checks++;
    if (state_o !== '0 || busy_o !== 1'b0 || perm_start_o !== 1'b0)
      $display("FAIL rst_perm_after busy=%b start=%b state=%h exp=0", busy_o, perm_start_o, state_o);
    else n_pass++;
    n_checks++;
    if (done_cnt != d0) $display("FAIL rst_perm_no_done got=%0d exp=%0d", done_cnt, d0);
    else n_pass++;
    perm_lat = 3;
  endtask

  initial begin
    test_reset();
    test_empty();
    test_full_partial();
    test_exact16();
    test_last_at_cnt1();
    test_partial_bytes();
    test_handshake();
    test_reset_in_perm();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule
